// File: rtl/reg_file_wb.sv
// reg_file_wb
//   Architectural register file at the end of the write-back path. One write
//   port (wb_*) updates the array at the clock edge; two combinational read
//   ports (ra_*/rb_*) serve decode with a same-cycle bypass from the write-back
//   port. A per-register pending-write counter tracks writes issued but not yet
//   written back, and blocks issue on source or destination hazards.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   wb_result, wb_rd, wb_write write-back data / destination / enable
//   ra_addr, rb_addr           read port addresses
//   ra_used, rb_used           issuing instruction consumes port A / B
//   iss_valid, iss_wen, iss_rd issue request, writes-a-register flag, destination
//   ra_data, rb_data           read data (combinational, bypassed)
//   stall                      issue blocked this cycle (combinational)
//   iss_accept                 iss_valid & ~stall
module reg_file_wb #(
    parameter int DW     = 32,
    parameter int AW     = 4,
    parameter int NREG   = 16,
    parameter int PEND_W = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] wb_result,
    input  logic [AW-1:0] wb_rd,
    input  logic          wb_write,
    input  logic [AW-1:0] ra_addr,
    input  logic [AW-1:0] rb_addr,
    input  logic          ra_used,
    input  logic          rb_used,
    input  logic          iss_valid,
    input  logic          iss_wen,
    input  logic [AW-1:0] iss_rd,
    output logic [DW-1:0] ra_data,
    output logic [DW-1:0] rb_data,
    output logic          stall,
    output logic          iss_accept
);

    logic [DW-1:0]     regs_q [NREG];
    logic [DW-1:0]     regs_d [NREG];
    logic [PEND_W-1:0] pend_q [NREG];
    logic [PEND_W-1:0] pend_d [NREG];

    logic haz_a;
    logic haz_b;
    logic haz_d;

    // Read ports with zero-latency bypass from the write-back port.
    always_comb begin
        ra_data = (wb_write && (wb_rd == ra_addr)) ? wb_result : regs_q[ra_addr];
        rb_data = (wb_write && (wb_rd == rb_addr)) ? wb_result : regs_q[rb_addr];
    end

    // A source is clear if nothing is pending, or if the write arriving this
    // cycle is the last outstanding one (its data is on the bypass).
    always_comb begin
        haz_a = ra_used && (pend_q[ra_addr] != '0) &&
                !(wb_write && (wb_rd == ra_addr) && (pend_q[ra_addr] == PEND_W'(1)));
        haz_b = rb_used && (pend_q[rb_addr] != '0) &&
                !(wb_write && (wb_rd == rb_addr) && (pend_q[rb_addr] == PEND_W'(1)));
        // Counter saturated: one more in-flight write cannot be tracked.
        haz_d = iss_wen && (pend_q[iss_rd] == '1);
        stall      = iss_valid && (haz_a || haz_b || haz_d);
        iss_accept = iss_valid && !stall;
    end

    always_comb begin
        logic inc;
        logic dec;
        for (int unsigned r = 0; r < NREG; r++) begin
            regs_d[r] = regs_q[r];
            pend_d[r] = pend_q[r];
        end
        if (wb_write) begin
            regs_d[wb_rd] = wb_result;
        end
        for (int unsigned r = 0; r < NREG; r++) begin
            inc = iss_accept && iss_wen && (iss_rd == AW'(r));
            // A stray write-back to an idle register leaves the counter at zero.
            dec = wb_write && (wb_rd == AW'(r)) && (pend_q[r] != '0);
            if (inc && !dec) begin
                pend_d[r] = pend_q[r] + PEND_W'(1);
            end else if (dec && !inc) begin
                pend_d[r] = pend_q[r] - PEND_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= '0;
                pend_q[r] <= '0;
            end
        end else begin
            for (int unsigned r = 0; r < NREG; r++) begin
                regs_q[r] <= regs_d[r];
                pend_q[r] <= pend_d[r];
            end
        end
    end

endmodule

// File: tb/tb_reg_file_wb.sv
// tb_reg_file_wb
//   Directed bench for reg_file_wb. Inputs are driven 1 time unit after the
//   rising edge and outputs checked 1 unit later, well away from the edge.
//   Pending-counter values are observed through stall/iss_accept behaviour.
module tb_reg_file_wb;

    localparam int DW = 32;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] wb_result;
    logic [AW-1:0] wb_rd;
    logic          wb_write;
    logic [AW-1:0] ra_addr;
    logic [AW-1:0] rb_addr;
    logic          ra_used;
    logic          rb_used;
    logic          iss_valid;
    logic          iss_wen;
    logic [AW-1:0] iss_rd;
    logic [DW-1:0] ra_data;
    logic [DW-1:0] rb_data;
    logic          stall;
    logic          iss_accept;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reg_file_wb #(.DW(DW), .AW(AW), .NREG(16), .PEND_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .wb_result  (wb_result),
        .wb_rd      (wb_rd),
        .wb_write   (wb_write),
        .ra_addr    (ra_addr),
        .rb_addr    (rb_addr),
        .ra_used    (ra_used),
        .rb_used    (rb_used),
        .iss_valid  (iss_valid),
        .iss_wen    (iss_wen),
        .iss_rd     (iss_rd),
        .ra_data    (ra_data),
        .rb_data    (rb_data),
        .stall      (stall),
        .iss_accept (iss_accept)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to 1 unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb_write  = 1'b0;
        wb_rd     = '0;
        wb_result = '0;
        ra_used   = 1'b0;
        rb_used   = 1'b0;
        iss_valid = 1'b0;
        iss_wen   = 1'b0;
        iss_rd    = '0;
    endtask

    task automatic wb(input logic [AW-1:0] rd, input logic [DW-1:0] data);
        wb_write  = 1'b1;
        wb_rd     = rd;
        wb_result = data;
    endtask

    task automatic issue_wr(input logic [AW-1:0] rd);
        iss_valid = 1'b1;
        iss_wen   = 1'b1;
        iss_rd    = rd;
        ra_used   = 1'b0;
        rb_used   = 1'b0;
    endtask

    initial begin
        idle();
        ra_addr = '0;
        rb_addr = '0;
        rst_n   = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;

        // T1: reset clears a written register, and beats a same-cycle write.
        wb(4'd3, 32'hDEAD);
        tick();
        idle();
        ra_addr = 4'd3;
        #1 check("t1_written", ra_data, 32'hDEAD);
        rst_n = 1'b0;
        wb(4'd3, 32'h1111);
        tick();
        rst_n = 1'b1;
        idle();
        iss_valid = 1'b1;
        ra_used   = 1'b1;
        #1 check("t1_ra_zero", ra_data, 32'h0);
        check("t1_stall", stall, 1'b0);
        check("t1_accept", iss_accept, 1'b1);
        idle();

        // T2: bypass on both ports with identical addresses, then registered value.
        tick();
        wb(4'd5, 32'h12345678);
        ra_addr = 4'd5;
        rb_addr = 4'd5;
        #1 check("t2_bypass_a", ra_data, 32'h12345678);
        check("t2_bypass_b", rb_data, 32'h12345678);
        tick();
        idle();
        #1 check("t2_stored", ra_data, 32'h12345678);

        // T3: RAW hazard on port A resolved by the single outstanding write.
        issue_wr(4'd7);
        #1 check("t3_issue_acc", iss_accept, 1'b1);
        tick();
        iss_wen = 1'b0;
        ra_addr = 4'd7;
        ra_used = 1'b1;
        #1 check("t3_stall", stall, 1'b1);
        check("t3_no_acc", iss_accept, 1'b0);
        tick();
        #1 check("t3_stall_hold", stall, 1'b1);
        wb(4'd7, 32'hA5);
        #1 check("t3_wb_stall", stall, 1'b0);
        check("t3_wb_data", ra_data, 32'hA5);
        tick();
        wb_write = 1'b0;
        #1 check("t3_pend0", stall, 1'b0);
        check("t3_data", ra_data, 32'hA5);
        idle();

        // T4: two writes in flight to R2; only the last one unblocks port B.
        issue_wr(4'd2);
        tick();
        issue_wr(4'd2);
        #1 check("t4_second_acc", iss_accept, 1'b1);
        tick();
        iss_wen = 1'b0;
        rb_addr = 4'd2;
        rb_used = 1'b1;
        #1 check("t4_stall2", stall, 1'b1);
        wb(4'd2, 32'h111);
        #1 check("t4_first_wb", stall, 1'b1);
        tick();
        wb_write = 1'b0;
        #1 check("t4_stall1", stall, 1'b1);
        check("t4_data1", rb_data, 32'h111);
        wb(4'd2, 32'h222);
        #1 check("t4_last_wb", stall, 1'b0);
        check("t4_bypass", rb_data, 32'h222);
        tick();
        wb_write = 1'b0;
        #1 check("t4_clear", stall, 1'b0);
        idle();

        // T5: saturation of the pending counter and simultaneous inc/dec.
        for (int i = 0; i < 3; i++) begin
            issue_wr(4'd9);
            #1 check("t5_fill_acc", iss_accept, 1'b1);
            tick();
        end
        #1 check("t5_sat_stall", stall, 1'b1);
        check("t5_sat_acc", iss_accept, 1'b0);
        tick();
        #1 check("t5_sat_hold", stall, 1'b1);
        idle();
        wb(4'd9, 32'h1);
        tick();
        // pend[9] = 2: write-back and issue together leave it at 2.
        wb(4'd9, 32'h2);
        issue_wr(4'd9);
        #1 check("t5_combo_acc", iss_accept, 1'b1);
        tick();
        wb_write = 1'b0;
        #1 check("t5_to3_acc", iss_accept, 1'b1);
        tick();
        #1 check("t5_at3_stall", stall, 1'b1);
        idle();
        for (int i = 0; i < 3; i++) begin
            wb(4'd9, 32'h30 + i);
            tick();
        end
        idle();
        iss_valid = 1'b1;
        ra_addr   = 4'd9;
        ra_used   = 1'b1;
        #1 check("t5_drained", stall, 1'b0);
        check("t5_data", ra_data, 32'h32);
        idle();

        // T6: stray write-back to an idle register; counter must not underflow.
        iss_valid = 1'b1;
        ra_addr   = 4'd4;
        ra_used   = 1'b1;
        wb(4'd4, 32'hBEEF);
        #1 check("t6_no_stall", stall, 1'b0);
        check("t6_bypass", ra_data, 32'hBEEF);
        tick();
        idle();
        #1 check("t6_stored", ra_data, 32'hBEEF);
        issue_wr(4'd4);
        #1 check("t6_issue_acc", iss_accept, 1'b1);
        tick();
        iss_wen = 1'b0;
        ra_used = 1'b1;
        #1 check("t6_pend1", stall, 1'b1);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
